// File: rtl/divisor_restoring.sv
// Sequential restoring shift-subtract divider: Q = A / B, R = A mod B, unsigned,
// one quotient bit per clock, START/END_DIV handshake.
module divisor_restoring #(
   parameter int unsigned size = 8
) (
   input  logic            CLOCK,
   input  logic            RESET,
   input  logic            START,
   input  logic [size-1:0] A,
   input  logic [size-1:0] B,
   output logic [size-1:0] Q,
   output logic [size-1:0] R,
   output logic            END_DIV,
   output logic            DIV_ZERO,
   output logic            BUSY
);

   localparam int unsigned CW = $clog2(size + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_q, state_d;
   // Partial remainder kept at size bits: its top bit is always 0 between
   // iterations, only the shifted value needs the extra bit.
   logic [size-1:0] p_q, p_d;
   logic [size-1:0] qs_q, qs_d;
   logic [size-1:0] m_q, m_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [size-1:0] quo_q, quo_d;
   logic [size-1:0] rem_q, rem_d;
   logic            end_q, end_d;
   logic            dz_q, dz_d;

   logic [size:0]   p_sh;
   logic [size:0]   t;

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         p_q     <= '0;
         qs_q    <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         end_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         qs_q    <= qs_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         end_q   <= end_d;
         dz_q    <= dz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      qs_d    = qs_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      end_d   = 1'b0;
      dz_d    = dz_q;

      p_sh = {p_q, qs_q[size-1]};
      t    = p_sh - {1'b0, m_q};

      unique case (state_q)
         IDLE: begin
            if (START) begin
               p_d     = '0;
               qs_d    = A;
               m_d     = B;
               cnt_d   = CW'(size);
               state_d = CALC;
            end
         end
         CALC: begin
            // Negative trial difference restores the shifted remainder.
            if (t[size]) begin
               p_d = p_sh[size-1:0];
            end else begin
               p_d = t[size-1:0];
            end
            qs_d  = {qs_q[size-2:0], ~t[size]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            quo_d   = qs_q;
            rem_d   = p_q;
            dz_d    = (m_q == '0);
            end_d   = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign Q        = quo_q;
   assign R        = rem_q;
   assign END_DIV  = end_q;
   assign DIV_ZERO = dz_q;
   assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_divisor_restoring.sv
// Self-checking bench for divisor_restoring: pending-operation queue plus
// plain-arithmetic reference, checked every cycle on the falling edge.
module tb_divisor_restoring;

   localparam int unsigned SIZE = 8;

   logic            CLOCK = 1'b0;
   logic            RESET = 1'b0;
   logic            START = 1'b0;
   logic [SIZE-1:0] A = '0;
   logic [SIZE-1:0] B = '0;
   logic [SIZE-1:0] Q;
   logic [SIZE-1:0] R;
   logic            END_DIV;
   logic            DIV_ZERO;
   logic            BUSY;

   divisor_restoring #(.size(SIZE)) dut (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .START    (START),
      .A        (A),
      .B        (B),
      .Q        (Q),
      .R        (R),
      .END_DIV  (END_DIV),
      .DIV_ZERO (DIV_ZERO),
      .BUSY     (BUSY)
   );

   always #5 CLOCK = ~CLOCK;

   int unsigned cyc = 0;
   always @(posedge CLOCK) cyc <= cyc + 1;

   typedef struct {
      int unsigned start;
      logic [7:0]  a;
      logic [7:0]  b;
   } op_t;

   op_t        pend[$];
   int         n_chk  = 0;
   int         n_fail = 0;
   bit         model_on = 1'b0;
   logic [7:0] hold_q = '0;
   logic [7:0] hold_r = '0;
   logic       hold_dz = 1'b0;

   function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                   output logic [7:0] q, output logic [7:0] r,
                                   output logic dz);
      if (b == 8'd0) begin
         q = 8'hFF; r = a; dz = 1'b1;
      end else begin
         q = a / b; r = a % b; dz = 1'b0;
      end
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Cycle-level expectations: END_DIV lands 9 edges after the START edge,
   // BUSY covers the edges in between, outputs otherwise hold.
   always @(negedge CLOCK) begin : cmp
      logic       exp_end;
      logic       exp_busy;
      logic [7:0] eq;
      logic [7:0] er;
      logic       edz;
      if (model_on && RESET) begin
         exp_end  = (pend.size() > 0) && (cyc == pend[0].start + 32'd9);
         exp_busy = (pend.size() > 0) && (cyc <= pend[0].start + 32'd8);
         check("end_div", int'(END_DIV), int'(exp_end));
         check("busy", int'(BUSY), int'(exp_busy));
         if (exp_end) begin
            ref_div(pend[0].a, pend[0].b, eq, er, edz);
            hold_q  = eq;
            hold_r  = er;
            hold_dz = edz;
            void'(pend.pop_front());
         end
         check("q", int'(Q), int'(hold_q));
         check("r", int'(R), int'(hold_r));
         check("div_zero", int'(DIV_ZERO), int'(hold_dz));
      end
   end

   task automatic start_op(input logic [7:0] a, input logic [7:0] b);
      A = a;
      B = b;
      START = 1'b1;
      @(posedge CLOCK);
      #1;
      pend.push_back('{cyc, a, b});
      START = 1'b0;
      A = 8'($urandom);
      B = 8'($urandom);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (pend.size() > 0 && k < 40) begin
         @(posedge CLOCK);
         k++;
      end
      #1;
      check("op_timeout", pend.size(), 0);
      pend.delete();
   endtask

   task automatic run_lit(input logic [7:0] a, input logic [7:0] b,
                          input int eq, input int er, input int edz);
      logic [7:0] mq;
      logic [7:0] mr;
      logic       mdz;
      ref_div(a, b, mq, mr, mdz);
      check("model_q", int'(mq), eq);
      check("model_r", int'(mr), er);
      check("model_dz", int'(mdz), edz);
      start_op(a, b);
      wait_idle();
      check("lit_q", int'(Q), eq);
      check("lit_r", int'(R), er);
      check("lit_dz", int'(DIV_ZERO), edz);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      repeat (3) @(posedge CLOCK);
      #1;
      check("rst_q", int'(Q), 0);
      check("rst_r", int'(R), 0);
      check("rst_end", int'(END_DIV), 0);
      check("rst_dz", int'(DIV_ZERO), 0);
      check("rst_busy", int'(BUSY), 0);
      RESET = 1'b1;
      model_on = 1'b1;
      @(posedge CLOCK);
      #1;

      run_lit(8'd35, 8'd7, 5, 0, 0);
      run_lit(8'd255, 8'd16, 15, 15, 0);
      run_lit(8'd3, 8'd200, 0, 3, 0);
      run_lit(8'd255, 8'd1, 255, 0, 0);
      run_lit(8'd100, 8'd0, 255, 100, 1);
      run_lit(8'd10, 8'd3, 3, 1, 0);

      // START and operands disturbed during CALC must not affect the result.
      start_op(8'd200, 8'd9);
      repeat (3) @(posedge CLOCK);
      #1;
      START = 1'b1;
      A = 8'd17;
      B = 8'd4;
      @(posedge CLOCK);
      #1;
      START = 1'b0;
      wait_idle();
      check("ign_q", int'(Q), 22);
      check("ign_r", int'(R), 2);

      // START held high: each new op is sampled 10 edges after the previous.
      START = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom_range(1, 255));
         A = ra;
         B = rb;
         @(posedge CLOCK);
         #1;
         pend.push_back('{cyc, ra, rb});
         if (i < 3) begin
            repeat (9) @(posedge CLOCK);
            #1;
         end
      end
      START = 1'b0;
      wait_idle();

      // Asynchronous reset between edges in the middle of CALC.
      start_op(8'd35, 8'd7);
      repeat (4) @(posedge CLOCK);
      #2;
      RESET = 1'b0;
      #1;
      check("arst_q", int'(Q), 0);
      check("arst_r", int'(R), 0);
      check("arst_end", int'(END_DIV), 0);
      check("arst_dz", int'(DIV_ZERO), 0);
      check("arst_busy", int'(BUSY), 0);
      pend.delete();
      hold_q  = '0;
      hold_r  = '0;
      hold_dz = 1'b0;
      @(posedge CLOCK);
      #1;
      RESET = 1'b1;
      @(posedge CLOCK);
      #1;
      run_lit(8'd35, 8'd7, 5, 0, 0);

      // Random sweep with forced corner bins.
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 5))
            0: begin ra = 8'($urandom); rb = 8'd0; end
            1: begin
               rb = 8'($urandom_range(1, 255));
               ra = 8'($urandom_range(0, int'(rb) - 1));
            end
            2: begin ra = 8'($urandom); rb = ra; end
            3: begin ra = 8'hFF; rb = 8'($urandom); end
            4: begin ra = 8'($urandom); rb = 8'hFF; end
            default: begin ra = 8'($urandom); rb = 8'($urandom); end
         endcase
         start_op(ra, rb);
         wait_idle();
      end

      model_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
